// File: rtl/matrix_result_streamer.sv
// Captures a packed product matrix on start and streams its elements out in
// row-major order over a valid/ready handshake, pulsing done after the last one.
module matrix_result_streamer #(
    parameter int unsigned MAX_DIM = 5,
    parameter int unsigned ELEM_W  = 16,
    localparam int unsigned DimW   = $clog2(MAX_DIM + 1),
    localparam int unsigned MatW   = MAX_DIM * MAX_DIM * ELEM_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic              in_error_i,
    input  logic [DimW-1:0]   c_m_i,
    input  logic [DimW-1:0]   c_n_i,
    input  logic [MatW-1:0]   a_mul_b_i,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [ELEM_W-1:0] out_data_o,
    output logic [DimW-1:0]   out_row_o,
    output logic [DimW-1:0]   out_col_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [DimW-1:0] MaxDim = DimW'(MAX_DIM);
    localparam logic [DimW-1:0] One    = DimW'(1);

    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    state_e            state_q, state_d;
    logic [DimW-1:0]   row_q, row_d;
    logic [DimW-1:0]   col_q, col_d;
    logic [DimW-1:0]   m_q, m_d;
    logic [DimW-1:0]   n_q, n_d;
    logic [MatW-1:0]   mat_q, mat_d;
    logic              err_q, err_d;

    logic              reject;
    logic              col_wrap;
    logic              at_last;
    logic              sending;
    logic [31:0]       elem_idx;

    assign reject   = !in_valid_i || in_error_i ||
                      (c_m_i == '0) || (c_n_i == '0) ||
                      (c_m_i > MaxDim) || (c_n_i > MaxDim);
    assign col_wrap = (col_q == n_q - One);
    assign at_last  = col_wrap && (row_q == m_q - One);
    assign sending  = (state_q == StSend);
    // Packed layout always uses MAX_DIM as the row stride, whatever c_n is.
    assign elem_idx = 32'(row_q) * MAX_DIM + 32'(col_q);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        m_d     = m_q;
        n_d     = n_q;
        mat_d   = mat_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        mat_d   = a_mul_b_i;
                        m_d     = c_m_i;
                        n_d     = c_n_i;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = StSend;
                    end
                end
            end
            StSend: begin
                if (out_ready_i) begin
                    if (col_wrap) begin
                        col_d = '0;
                        row_d = row_q + One;
                    end else begin
                        col_d = col_q + One;
                    end
                    if (at_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            m_q     <= '0;
            n_q     <= '0;
            mat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            m_q     <= m_d;
            n_q     <= n_d;
            mat_q   <= mat_d;
            err_q   <= err_d;
        end
    end

    assign out_valid_o = sending;
    assign out_data_o  = sending ? mat_q[elem_idx*ELEM_W +: ELEM_W] : '0;
    assign out_row_o   = sending ? row_q : '0;
    assign out_col_o   = sending ? col_q : '0;
    assign out_last_o  = sending && at_last;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign err_o       = err_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Randomized bench for matrix_result_streamer: each accepted start is checked
// against a row-major element list built from the captured matrix.
module tb_matrix_result_streamer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         in_valid;
    logic         in_error;
    logic [2:0]   c_m;
    logic [2:0]   c_n;
    logic [399:0] a_mul_b;
    logic         out_ready;
    logic         out_valid;
    logic [15:0]  out_data;
    logic [2:0]   out_row;
    logic [2:0]   out_col;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    matrix_result_streamer dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .in_valid_i  (in_valid),
        .in_error_i  (in_error),
        .c_m_i       (c_m),
        .c_n_i       (c_n),
        .a_mul_b_i   (a_mul_b),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_row_o   (out_row),
        .out_col_o   (out_col),
        .out_last_o  (out_last),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 0);
        check_eq({tag, "_data"},  32'(out_data),  0);
        check_eq({tag, "_row"},   32'(out_row),   0);
        check_eq({tag, "_col"},   32'(out_col),   0);
        check_eq({tag, "_last"},  32'(out_last),  0);
        check_eq({tag, "_busy"},  32'(busy),      0);
        check_eq({tag, "_done"},  32'(done),      0);
        check_eq({tag, "_err"},   32'(err),       0);
    endtask

    function automatic logic [399:0] rand_mat();
        logic [399:0] m;
        for (int i = 0; i < 25; i++) m[i*16 +: 16] = 16'($urandom);
        return m;
    endfunction

    // mode 0: ready always 1; mode 1: ready 1,0,1,0...; mode 2: random ready
    task automatic run_stream(input int m, input int n, input logic [399:0] mat,
                              input int mode, input bit disturb);
        logic [15:0] exp_data [$];
        int   k   = 0;
        int   cyc = 0;
        bit   tog = 1'b1;
        bit   rdy;
        for (int r = 0; r < m; r++)
            for (int c = 0; c < n; c++)
                exp_data.push_back(mat[(r*5 + c)*16 +: 16]);
        start    = 1'b1;
        in_valid = 1'b1;
        in_error = 1'b0;
        c_m      = 3'(m);
        c_n      = 3'(n);
        a_mul_b  = mat;
        step();
        start = 1'b0;
        cyc   = 1;
        check_eq("valid_after_start", 32'(out_valid), 1);
        while (k < m*n && cyc < 400) begin
            check_eq("s_valid", 32'(out_valid), 1);
            check_eq("s_busy",  32'(busy), 1);
            check_eq("s_done",  32'(done), 0);
            check_eq("s_err",   32'(err), 0);
            check_eq("s_row",   32'(out_row), 32'(k / n));
            check_eq("s_col",   32'(out_col), 32'(k % n));
            check_eq("s_data",  32'(out_data), 32'(exp_data[k]));
            check_eq("s_last",  32'(out_last), 32'(k == m*n - 1));
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) begin rdy = tog; tog = ~tog; end
            else                rdy = ($urandom_range(0, 3) != 0);
            out_ready = rdy;
            if (disturb) begin
                a_mul_b  = rand_mat();
                c_m      = 3'($urandom);
                c_n      = 3'($urandom);
                in_valid = 1'($urandom);
                in_error = 1'($urandom);
                start    = 1'($urandom);
            end
            step();
            cyc++;
            if (rdy) k++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_error  = 1'b0;
        check_eq("handshakes", 32'(k), 32'(m*n));
        if (mode == 0) check_eq("done_latency", 32'(cyc), 32'(1 + m*n));
        check_eq("d_done",  32'(done), 1);
        check_eq("d_busy",  32'(busy), 1);
        check_eq("d_valid", 32'(out_valid), 0);
        check_eq("d_data",  32'(out_data), 0);
        check_eq("d_row",   32'(out_row), 0);
        check_eq("d_col",   32'(out_col), 0);
        check_eq("d_last",  32'(out_last), 0);
        check_eq("d_err",   32'(err), 0);
        step();
        check_quiet("post_done");
    endtask

    task automatic run_reject(input int m, input int n, input bit v, input bit e);
        start    = 1'b1;
        in_valid = v;
        in_error = e;
        c_m      = 3'(m);
        c_n      = 3'(n);
        a_mul_b  = rand_mat();
        step();
        start = 1'b0;
        check_eq("rej_err",   32'(err), 1);
        check_eq("rej_busy",  32'(busy), 0);
        check_eq("rej_valid", 32'(out_valid), 0);
        step();
        in_valid = 1'b1;
        in_error = 1'b0;
        check_eq("rej_err_clear", 32'(err), 0);
        check_eq("rej_busy2",     32'(busy), 0);
        check_eq("rej_valid2",    32'(out_valid), 0);
    endtask

    initial begin
        logic [399:0] mat;
        int           m;
        int           n;
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_error  = 1'b0;
        c_m       = '0;
        c_n       = '0;
        a_mul_b   = '0;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_quiet("reset");

        // 2x3 of 1..6
        mat = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                mat[(r*5 + c)*16 +: 16] = 16'(r*3 + c + 1);
        run_stream(2, 3, mat, 0, 1'b0);

        // 1x1 all ones
        mat = '0;
        mat[15:0] = 16'hFFFF;
        run_stream(1, 1, mat, 0, 1'b0);

        // 5x5 with toggling ready
        run_stream(5, 5, rand_mat(), 1, 1'b0);

        run_reject(2, 2, 1'b1, 1'b1);
        run_reject(2, 6, 1'b1, 1'b0);
        run_reject(2, 2, 1'b0, 1'b0);
        run_reject(0, 3, 1'b1, 1'b0);
        run_reject(3, 0, 1'b1, 1'b0);
        run_reject(7, 1, 1'b1, 1'b0);

        // reset after 3 handshakes of a 3x3 stream, asserted alongside start/ready
        start    = 1'b1;
        in_valid = 1'b1;
        c_m      = 3'd3;
        c_n      = 3'd3;
        a_mul_b  = rand_mat();
        step();
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        check_eq("pre_reset_row", 32'(out_row), 1);
        check_eq("pre_reset_col", 32'(out_col), 0);
        reset = 1'b1;
        start = 1'b1;
        step();
        reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        check_quiet("mid_reset");
        step();
        check_quiet("after_reset");
        run_stream(3, 3, rand_mat(), 0, 1'b0);

        // mid-stream start and input churn must not disturb the stream
        run_stream(3, 3, rand_mat(), 0, 1'b1);
        run_stream(4, 5, rand_mat(), 2, 1'b1);

        for (int it = 0; it < 30; it++) begin
            m = $urandom_range(1, 5);
            n = $urandom_range(1, 5);
            if ($urandom_range(0, 4) == 0)
                run_reject(m, n, 1'b1, 1'b1);
            else
                run_stream(m, n, rand_mat(), $urandom_range(0, 2), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
